seven_seg_scan_ctrl: RTL

Time-multiplexed scan controller for a multi-digit common-cathode 7-segment display.
- Drives one shared `seven_segment_decoder` instance, steering one BCD digit at a time onto it.
- Enables the matching digit driver in a fixed rotation.
- Adds a per-slot anti-ghosting blanking interval, tear-free frame-synchronous updates and optional leading-zero suppression.
- Sits between the register/counter logic producing BCD values and the display pins.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_scan_timer.sv | 29 ++
 rtl/seven_seg_scan_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, slot-state type and helpers for the multiplexed 7-segment scan controller.
package seven_seg_pkg;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  BCD_BLANK  = 4'hF;
  localparam int unsigned MAX_DIGITS = 8;

  typedef enum logic {
    SLOT_BLANK,
    SLOT_ON
  } slot_state_e;

  // Callers size-cast the result down to their own digit count.
  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input int unsigned index);
    return MAX_DIGITS'(1) << index;
  endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Per-slot cycle counter: flags the last cycle of a slot and the anti-ghosting blank window.
module scan_timer #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_wrap,
  output logic in_blank
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;

  assign slot_wrap = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign in_blank  = (cnt < CNT_W'(BLANK_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (slot_wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller: rotates BCD digits onto one shared decoder with
// per-slot blanking, frame-synchronous data updates and optional leading-zero suppression.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  input  logic                      blank_leading,
  output logic [BCD_W-1:0]          bcd_out,
  output logic [NUM_DIGITS-1:0]     digit_en_out,
  output logic                      dp_out,
  output logic                      frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic                              slot_wrap;
  logic                              in_blank;
  logic                              frame_end;
  logic [IDX_W-1:0]                  idx;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]  pending_digits;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]  active_digits;
  logic [NUM_DIGITS-1:0]             pending_dp;
  logic [NUM_DIGITS-1:0]             active_dp;
  logic [NUM_DIGITS-1:1]             zero_from;
  logic [NUM_DIGITS-1:0]             suppress;
  slot_state_e                       slot_state;
  logic [BCD_W-1:0]                  bcd_nxt;
  logic [NUM_DIGITS-1:0]             en_nxt;
  logic                              dp_nxt;

  scan_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .slot_wrap (slot_wrap),
    .in_blank  (in_blank)
  );

  assign frame_end = slot_wrap && (idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (slot_wrap) begin
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the frame boundary bypasses pending so it is shown next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_digits <= '0;
      pending_dp     <= '0;
      active_digits  <= '0;
      active_dp      <= '0;
    end else begin
      if (load) begin
        pending_digits <= digits_in;
        pending_dp     <= dp_in;
      end
      if (frame_end) begin
        active_digits <= load ? digits_in : pending_digits;
        active_dp     <= load ? dp_in     : pending_dp;
      end
    end
  end

  // zero_from[k]: active digits k..NUM_DIGITS-1 are all zero.
  assign zero_from[NUM_DIGITS-1] = (active_digits[NUM_DIGITS-1] == '0);
  for (genvar k = 1; k < NUM_DIGITS - 1; k++) begin : g_zero
    assign zero_from[k] = (active_digits[k] == '0) && zero_from[k+1];
  end
  assign suppress = blank_leading ? {zero_from, 1'b0} : '0;

  always_comb begin
    slot_state = in_blank ? SLOT_BLANK : SLOT_ON;
    bcd_nxt    = suppress[idx] ? BCD_BLANK : active_digits[idx];
    dp_nxt     = active_dp[idx];
    en_nxt     = '0;
    if (slot_state == SLOT_ON) begin
      en_nxt = NUM_DIGITS'(digit_onehot(32'(idx)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out      <= '0;
      digit_en_out <= '0;
      dp_out       <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      bcd_out      <= bcd_nxt;
      digit_en_out <= en_nxt;
      dp_out       <= dp_nxt;
      frame_done   <= frame_end;
    end
  end

endmodule
